// File: rtl/multicycle_processor_pkg.sv
// Shared types, encodings and the boot memory image for the multicycle processor.
package multicycle_processor_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 7;
  localparam int IR_W      = 9;
  localparam int MEM_DEPTH = 128;

  typedef enum logic [2:0] {
    OP_MV   = 3'd0,
    OP_MVI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_MVNZ = 3'd4,
    OP_LD   = 3'd5,
    OP_ST   = 3'd6,
    OP_NOP  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } tstep_e;

  typedef enum logic [3:0] {
    SEL_R0   = 4'd0,
    SEL_R1   = 4'd1,
    SEL_R2   = 4'd2,
    SEL_R3   = 4'd3,
    SEL_R4   = 4'd4,
    SEL_R5   = 4'd5,
    SEL_R6   = 4'd6,
    SEL_R7   = 4'd7,
    SEL_G    = 4'd8,
    SEL_DIN  = 4'd9,
    SEL_NONE = 4'd15
  } bus_sel_e;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  typedef logic [DATA_W-1:0] mem_t [0:MEM_DEPTH-1];

  // Boot image; unlisted words hold the no-op encoding so a runaway PC stays harmless.
  localparam mem_t MEM_INIT = '{
    0:  16'h0050, 1:  16'h0001, 2:  16'h0060, 3:  16'h000A,
    4:  16'h00E2, 5:  16'h009C, 6:  16'h00DC, 7:  16'h013D,
    8:  16'h0034, 9:  16'h0048, 10: 16'h0064, 11: 16'h01B1,
    12: 16'h0141, 13: 16'h01C0, 14: 16'h00E2, 15: 16'h0058,
    16: 16'h0004, 17: 16'h00E3, 18: 16'h013D,
    default: 16'h01C0
  };

  function automatic bus_sel_e reg_sel(input logic [2:0] r);
    return bus_sel_e'({1'b0, r});
  endfunction

endpackage

// File: rtl/multicycle_processor_regn.sv
// 16-bit register with load enable and asynchronous active-low clear.
module regn
  import multicycle_processor_pkg::*;
(
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Rin,
  input  logic [DATA_W-1:0] R,
  output logic [DATA_W-1:0] Q
);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) Q <= '0;
    else if (Rin) Q <= R;
  end

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle 16-bit CPU: single shared bus, R7 as PC, fixed T0..T5 step counter.
module multicycle_processor
  import multicycle_processor_pkg::*;
(
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic [2:0]        Tstep,
  output logic [DATA_W-1:0] Rx_data,
  output logic [DATA_W-1:0] Ry_data
);

  // Handshake: Run is sampled only in T0 and starts a fetch when high; Done is
  // high for exactly the last step of an instruction and returns the counter to T0.

  tstep_e             tstep_q, tstep_d;
  logic [IR_W-1:0]    ir_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  dout_q;
  logic [DATA_W-1:0]  din;
  logic [DATA_W-1:0]  mem [0:MEM_DEPTH-1] = MEM_INIT;
  logic [DATA_W-1:0]  r_q [0:7];
  logic [DATA_W-1:0]  a_q, g_q, alu_result, r7_d;

  bus_sel_e   bus_sel;
  alu_op_e    alu_op;
  logic [7:0] rin;
  logic       ain, gin, irin, addrin, doutin, incr_pc, w_d, done;

  opcode_e    opcode;
  logic [2:0] rx, ry;

  assign opcode = opcode_e'(ir_q[8:6]);
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];

  always_comb begin
    bus_sel = SEL_NONE;
    alu_op  = ALU_ADD;
    rin     = '0;
    ain     = 1'b0;
    gin     = 1'b0;
    irin    = 1'b0;
    addrin  = 1'b0;
    doutin  = 1'b0;
    incr_pc = 1'b0;
    w_d     = 1'b0;
    done    = 1'b0;
    case (tstep_q)
      T0: if (Run) begin
        bus_sel = SEL_R7;
        addrin  = 1'b1;
        incr_pc = 1'b1;
      end
      T2: irin = 1'b1;
      T3: case (opcode)
        OP_MV: begin
          bus_sel = reg_sel(ry);
          rin[rx] = 1'b1;
          done    = 1'b1;
        end
        OP_MVI: begin
          bus_sel = SEL_R7;
          addrin  = 1'b1;
          incr_pc = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          bus_sel = reg_sel(rx);
          ain     = 1'b1;
        end
        OP_MVNZ: begin
          if (g_q != '0) begin
            bus_sel = reg_sel(ry);
            rin[rx] = 1'b1;
          end
          done = 1'b1;
        end
        OP_LD, OP_ST: begin
          bus_sel = reg_sel(ry);
          addrin  = 1'b1;
        end
        default: done = 1'b1;
      endcase
      T4: case (opcode)
        OP_ADD, OP_SUB: begin
          bus_sel = reg_sel(ry);
          gin     = 1'b1;
          alu_op  = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
        end
        OP_ST: begin
          bus_sel = reg_sel(rx);
          doutin  = 1'b1;
        end
        default: ;
      endcase
      T5: case (opcode)
        OP_MVI, OP_LD: begin
          bus_sel = SEL_DIN;
          rin[rx] = 1'b1;
          done    = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          bus_sel = SEL_G;
          rin[rx] = 1'b1;
          done    = 1'b1;
        end
        OP_ST: begin
          w_d  = 1'b1;
          done = 1'b1;
        end
        default: done = 1'b1;
      endcase
      default: ;
    endcase
  end

  always_comb begin
    tstep_d = tstep_q;
    if (done) tstep_d = T0;
    else begin
      case (tstep_q)
        T0:      if (Run) tstep_d = T1;
        T1:      tstep_d = T2;
        T2:      tstep_d = T3;
        T3:      tstep_d = T4;
        T4:      tstep_d = T5;
        default: tstep_d = T0;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tstep_q <= T0;
      ir_q    <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      tstep_q <= tstep_d;
      if (irin)   ir_q   <= din[IR_W-1:0];
      if (addrin) addr_q <= BusWires[ADDR_W-1:0];
      if (doutin) dout_q <= BusWires;
    end
  end

  // Synchronous memory: read data for an address registered in step n is on DIN in step n+2.
  always_ff @(posedge Clock) begin
    if (w_d) mem[addr_q] <= dout_q;
    din <= mem[addr_q];
  end

  always_comb begin
    case (bus_sel)
      SEL_R0, SEL_R1, SEL_R2, SEL_R3,
      SEL_R4, SEL_R5, SEL_R6, SEL_R7: BusWires = r_q[bus_sel[2:0]];
      SEL_G:   BusWires = g_q;
      SEL_DIN: BusWires = din;
      default: BusWires = '0;
    endcase
  end

  assign alu_result = (alu_op == ALU_SUB) ? a_q - BusWires : a_q + BusWires;
  assign r7_d       = incr_pc ? r_q[7] + 16'd1 : BusWires;

  regn R0 (.Clock(Clock), .Resetn(Resetn), .Rin(rin[0]), .R(BusWires), .Q(r_q[0]));
  regn R1 (.Clock(Clock), .Resetn(Resetn), .Rin(rin[1]), .R(BusWires), .Q(r_q[1]));
  regn R2 (.Clock(Clock), .Resetn(Resetn), .Rin(rin[2]), .R(BusWires), .Q(r_q[2]));
  regn R3 (.Clock(Clock), .Resetn(Resetn), .Rin(rin[3]), .R(BusWires), .Q(r_q[3]));
  regn R4 (.Clock(Clock), .Resetn(Resetn), .Rin(rin[4]), .R(BusWires), .Q(r_q[4]));
  regn R5 (.Clock(Clock), .Resetn(Resetn), .Rin(rin[5]), .R(BusWires), .Q(r_q[5]));
  regn R6 (.Clock(Clock), .Resetn(Resetn), .Rin(rin[6]), .R(BusWires), .Q(r_q[6]));
  regn R7 (.Clock(Clock), .Resetn(Resetn), .Rin(rin[7] | incr_pc), .R(r7_d), .Q(r_q[7]));
  regn A  (.Clock(Clock), .Resetn(Resetn), .Rin(ain), .R(BusWires),   .Q(a_q));
  regn G  (.Clock(Clock), .Resetn(Resetn), .Rin(gin), .R(alu_result), .Q(g_q));

  assign Done    = done;
  assign Tstep   = tstep_q;
  assign Rx_data = r_q[rx];
  assign Ry_data = r_q[ry];

endmodule

// File: tb/tb_multicycle_processor.sv
// Scoreboard bench for multicycle_processor running its boot program.
module tb_multicycle_processor;

  localparam int W = 52;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic        Done;
  logic [15:0] BusWires;
  logic [2:0]  Tstep;
  logic [15:0] Rx_data;
  logic [15:0] Ry_data;

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  multicycle_processor dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Done(Done),
    .BusWires(BusWires), .Tstep(Tstep), .Rx_data(Rx_data), .Ry_data(Ry_data)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {done step, has writeback, pc after, Rx value, G}
  task automatic push_exp(input int step, input bit has, input int pc, input int val, input int g);
    exp_q.push_back({step[2:0], has, pc[15:0], val[15:0], g[15:0]});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_tstep"}, {13'd0, Tstep}, 16'd0);
    check({tag, "_done"},  {15'd0, Done}, 16'd0);
    check({tag, "_bus"},   BusWires, 16'd0);
    check({tag, "_r0"}, dut.R0.Q, 16'd0);
    check({tag, "_r1"}, dut.R1.Q, 16'd0);
    check({tag, "_r2"}, dut.R2.Q, 16'd0);
    check({tag, "_r3"}, dut.R3.Q, 16'd0);
    check({tag, "_r4"}, dut.R4.Q, 16'd0);
    check({tag, "_r5"}, dut.R5.Q, 16'd0);
    check({tag, "_r6"}, dut.R6.Q, 16'd0);
    check({tag, "_r7"}, dut.R7.Q, 16'd0);
    check({tag, "_a"},  dut.A.Q,  16'd0);
    check({tag, "_g"},  dut.G.Q,  16'd0);
    check({tag, "_ir"}, {7'd0, dut.ir_q}, 16'd0);
  endtask

  task automatic wait_drained(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (exp_q.size() == 0) break;
    end
    if (i == budget) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expected results still pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // monitor / scoreboard
  logic [2:0]   mon_step;
  logic [W-1:0] mon_e;
  initial begin
    forever begin
      @(negedge Clock);
      if (Resetn && Done) begin
        mon_step = Tstep;
        @(posedge Clock);
        #1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: step %0d", mon_step);
        end else begin
          mon_e = exp_q[0];
          check("done_step", {13'd0, mon_step}, {13'd0, mon_e[51:49]});
          check("pc_r7", dut.R7.Q, mon_e[47:32]);
          check("g_reg", dut.G.Q, mon_e[15:0]);
          if (mon_e[48]) check("rx_data", Rx_data, mon_e[31:16]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // stimulus
  initial begin
    int k;
    Resetn = 1'b0;
    Run    = 1'b0;
    repeat (2) @(negedge Clock);
    check_cleared("reset");
    Resetn = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      check("idle_tstep", {13'd0, Tstep}, 16'd0);
      check("idle_bus", BusWires, 16'd0);
      check("idle_done", {15'd0, Done}, 16'd0);
      check("idle_pc", dut.R7.Q, 16'd0);
    end

    push_exp(5, 1,  2,   1, 0);  // mvi R2,1
    push_exp(5, 1,  4,  10, 0);  // mvi R4,10
    push_exp(5, 1,  5,   9, 9);  // sub R4,R2
    push_exp(5, 1,  6,   9, 9);  // add R3,R4
    push_exp(5, 1,  7,   0, 0);  // sub R3,R4
    push_exp(3, 1,  8,   8, 0);  // mvnz R7,R5 with G=0: no jump
    push_exp(3, 1,  9,   9, 0);  // mv R6,R4
    push_exp(5, 1, 11, 100, 0);  // mvi R1,100
    push_exp(5, 0, 12,   0, 0);  // st R6,R1
    push_exp(5, 1, 13,   9, 0);  // ld R0,R1
    push_exp(3, 0, 14,   0, 0);  // no-op
    push_exp(5, 1, 15,   8, 8);  // sub R4,R2
    push_exp(5, 1, 17,   4, 8);  // mvi R3,4
    push_exp(5, 1, 18,   4, 4);  // sub R4,R3
    push_exp(3, 1,  0,   0, 4);  // mvnz R7,R5 with G=4: jump to 0
    push_exp(5, 1,  2,   1, 4);  // mvi R2,1 again
    push_exp(5, 1,  4,  10, 4);  // mvi R4,10
    push_exp(5, 1,  5,   9, 9);  // sub R4,R2
    Run = 1'b1;
    wait_drained(400);

    for (k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (Tstep == 3'd4 && dut.ir_q[8:6] == 3'b010) break;
    end
    if (k == 40) begin
      n_cmp++;
      n_fail++;
      $display("FAIL add_t4_timeout: step %0d ir %0h", Tstep, dut.ir_q);
    end
    Resetn = 1'b0;
    #1;
    check_cleared("midreset");
    repeat (2) @(negedge Clock);
    push_exp(5, 1, 2,  1, 0);
    push_exp(5, 1, 4, 10, 0);
    Resetn = 1'b1;
    wait_drained(200);
    check("r3_no_writeback", dut.R3.Q, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
